// File: rtl/matrix_vector_loader_if.sv
// Handshake and operand bus between the serial element feeder and the
// matrix-vector loader; the loader sits on the slave side.
interface matrix_vector_loader_if #(
    parameter int N     = 32,
    parameter int LEN   = 4,
    parameter int WIDTH = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         abort;
    logic         reuse_vec;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] vectorout [LEN];
    logic [N-1:0] matrixout [WIDTH][LEN];

    modport master (
        output in_valid, in_data, abort, reuse_vec, out_ready,
        input  in_ready, out_valid, vectorout, matrixout
    );

    modport slave (
        input  in_valid, in_data, abort, reuse_vec, out_ready,
        output in_ready, out_valid, vectorout, matrixout
    );
endinterface

// File: rtl/matrix_vector_loader.sv
// Collects a serial element stream into a LEN-element vector and a WIDTH x LEN
// matrix, then holds both stable for the downstream multiplier while out_valid.
module matrix_vector_loader #(
    parameter int N     = 32,
    parameter int LEN   = 4,
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    matrix_vector_loader_if.slave bus
);
    localparam int VW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [VW-1:0] LAST_COL = VW'(LEN - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(WIDTH - 1);

    typedef enum logic [1:0] {
        LOAD_VEC = 2'd0,
        LOAD_MAT = 2'd1,
        FULL     = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [VW-1:0] vidx, vidx_next;
    logic [VW-1:0] col, col_next;
    logic [RW-1:0] row, row_next;
    logic          xfer;
    logic          vec_we;
    logic          mat_we;

    logic [N-1:0]  vec_q [LEN];
    logic [N-1:0]  mat_q [WIDTH][LEN];

    // in_ready is held low while reset is asserted so nothing is taken then.
    assign bus.in_ready  = (state != FULL) && !reset;
    assign bus.out_valid = (state == FULL);
    assign xfer          = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_VEC;
            vidx  <= '0;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            vidx  <= vidx_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    // abort outranks both an element transfer and the output handshake.
    always_comb begin
        state_next = state;
        vidx_next  = vidx;
        col_next   = col;
        row_next   = row;
        vec_we     = 1'b0;
        mat_we     = 1'b0;
        if (bus.abort) begin
            state_next = LOAD_VEC;
            vidx_next  = '0;
            col_next   = '0;
            row_next   = '0;
        end else begin
            case (state)
                LOAD_VEC: begin
                    if (xfer) begin
                        vec_we = 1'b1;
                        if (vidx == LAST_COL) begin
                            vidx_next  = '0;
                            state_next = LOAD_MAT;
                        end else begin
                            vidx_next = vidx + 1'b1;
                        end
                    end
                end
                LOAD_MAT: begin
                    if (xfer) begin
                        mat_we = 1'b1;
                        if (col == LAST_COL) begin
                            col_next = '0;
                            if (row == LAST_ROW) begin
                                row_next   = '0;
                                state_next = FULL;
                            end else begin
                                row_next = row + 1'b1;
                            end
                        end else begin
                            col_next = col + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state_next = bus.reuse_vec ? LOAD_MAT : LOAD_VEC;
                    end
                end
                default: begin
                    state_next = LOAD_VEC;
                end
            endcase
        end
    end

    // Operand storage: only the slot addressed by an accepted transfer changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < LEN; v++) begin
                vec_q[v] <= '0;
            end
            for (int r = 0; r < WIDTH; r++) begin
                for (int c = 0; c < LEN; c++) begin
                    mat_q[r][c] <= '0;
                end
            end
        end else begin
            if (vec_we) begin
                vec_q[vidx] <= bus.in_data;
            end
            if (mat_we) begin
                mat_q[row][col] <= bus.in_data;
            end
        end
    end

    assign bus.vectorout = vec_q;
    assign bus.matrixout = mat_q;
endmodule

// File: tb/tb_matrix_vector_loader.sv
// Self-checking bench for matrix_vector_loader against a slot-position model
// of the load sequence (vector slots first, then the matrix row-major).
module tb_matrix_vector_loader;
    localparam int N     = 32;
    localparam int LEN   = 4;
    localparam int WIDTH = 4;
    localparam int TOTAL = LEN + WIDTH * LEN;

    logic clk = 1'b0;
    logic reset;

    int errors = 0;
    int checks = 0;

    int           m_pos;
    bit           m_full;
    int           m_accepts;
    logic [N-1:0] m_vec [LEN];
    logic [N-1:0] m_mat [WIDTH][LEN];

    always #5 clk = ~clk;

    matrix_vector_loader_if #(.N(N), .LEN(LEN), .WIDTH(WIDTH)) bus ();

    matrix_vector_loader #(.N(N), .LEN(LEN), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Advance one clock, update the model from the inputs seen at the edge,
    // and return 1 time unit after the edge for sampling.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int v = 0; v < LEN; v++) m_vec[v] = '0;
            for (int r = 0; r < WIDTH; r++)
                for (int c = 0; c < LEN; c++) m_mat[r][c] = '0;
            m_pos  = 0;
            m_full = 0;
        end else if (bus.abort) begin
            m_pos  = 0;
            m_full = 0;
        end else if (m_full) begin
            if (bus.out_ready) begin
                m_full = 0;
                m_pos  = bus.reuse_vec ? LEN : 0;
            end
        end else if (bus.in_valid) begin
            if (m_pos < LEN) m_vec[m_pos] = bus.in_data;
            else m_mat[(m_pos - LEN) / LEN][(m_pos - LEN) % LEN] = bus.in_data;
            m_pos++;
            m_accepts++;
            if (m_pos == TOTAL) begin
                m_full = 1;
                m_pos  = 0;
            end
        end
        #1;
    endtask

    function automatic int content_diffs();
        int bad = 0;
        for (int v = 0; v < LEN; v++)
            if (bus.vectorout[v] !== m_vec[v]) bad++;
        for (int r = 0; r < WIDTH; r++)
            for (int c = 0; c < LEN; c++)
                if (bus.matrixout[r][c] !== m_mat[r][c]) bad++;
        return bad;
    endfunction

    task automatic consume(input logic reuse);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.reuse_vec = reuse;
        tick();
        bus.out_ready = 1'b0;
        bus.reuse_vec = 1'b0;
    endtask

    task automatic test_reset();
        int d;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.abort     = 1'b0;
        bus.reuse_vec = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        d = content_diffs();
        checks++;
        if (d !== 0) begin
            errors++; $display("[TB] FAIL reset_contents: %0d slots differ, expected 0", d);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_full_load();
        int d;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= TOTAL; i++) begin
            bus.in_data = N'(i);
            tick();
            checks++;
            if (bus.out_valid !== (i == TOTAL)) begin
                errors++; $display("[TB] FAIL load_out_valid at %0d: got %b expected %b", i, bus.out_valid, (i == TOTAL));
            end
        end
        d = content_diffs();
        checks++;
        if (d !== 0) begin
            errors++; $display("[TB] FAIL load_contents: %0d slots differ from model", d);
        end
        checks++;
        if (bus.vectorout[0] !== 32'd1 || bus.vectorout[3] !== 32'd4) begin
            errors++; $display("[TB] FAIL load_vec_ends: got %0d,%0d expected 1,4", bus.vectorout[0], bus.vectorout[3]);
        end
        checks++;
        if (bus.matrixout[0][0] !== 32'd5 || bus.matrixout[3][3] !== 32'd20) begin
            errors++; $display("[TB] FAIL load_mat_ends: got %0d,%0d expected 5,20", bus.matrixout[0][0], bus.matrixout[3][3]);
        end
        bus.in_data = 32'd99;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL full_flags: got ready=%b valid=%b expected ready=0 valid=1", bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reuse();
        int d;
        int bad;
        consume(1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reuse_handshake: got valid=%b ready=%b expected 0,1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        for (int i = 0; i < WIDTH * LEN; i++) begin
            bus.in_data = N'(100 + i);
            tick();
            checks++;
            if (bus.out_valid !== (i == WIDTH * LEN - 1)) begin
                errors++; $display("[TB] FAIL reuse_out_valid at %0d: got %b expected %b", i, bus.out_valid, (i == WIDTH * LEN - 1));
            end
        end
        bus.in_valid = 1'b0;
        bad = 0;
        for (int v = 0; v < LEN; v++)
            if (bus.vectorout[v] !== N'(v + 1)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("[TB] FAIL reuse_vec_kept: %0d vector slots changed, expected 0", bad);
        end
        checks++;
        if (bus.matrixout[0][0] !== 32'd100 || bus.matrixout[3][3] !== 32'd115) begin
            errors++; $display("[TB] FAIL reuse_mat_ends: got %0d,%0d expected 100,115", bus.matrixout[0][0], bus.matrixout[3][3]);
        end
        d = content_diffs();
        checks++;
        if (d !== 0) begin
            errors++; $display("[TB] FAIL reuse_contents: %0d slots differ from model", d);
        end
    endtask

    task automatic test_random_gaps();
        int   d;
        int   bad;
        int   acc;
        int   cyc;
        logic took;
        consume(1'b0);
        d   = 1;
        acc = 0;
        cyc = 0;
        while (!bus.out_valid && cyc < 400) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = N'(d);
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.reuse_vec = 1'($urandom_range(0, 1));
            took = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (took) begin
                d++;
                acc++;
            end
            checks++;
            if (bus.out_valid !== m_full) begin
                errors++; $display("[TB] FAIL gaps_out_valid cycle %0d: got %b expected %b", cyc, bus.out_valid, m_full);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.reuse_vec = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL gaps_timeout: out_valid=%b after %0d cycles, expected 1", bus.out_valid, cyc);
        end
        checks++;
        if (acc !== TOTAL) begin
            errors++; $display("[TB] FAIL gaps_count: got %0d transfers expected %0d", acc, TOTAL);
        end
        bad = 0;
        for (int v = 0; v < LEN; v++)
            if (bus.vectorout[v] !== N'(v + 1)) bad++;
        for (int r = 0; r < WIDTH; r++)
            for (int c = 0; c < LEN; c++)
                if (bus.matrixout[r][c] !== N'(LEN + 1 + r * LEN + c)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("[TB] FAIL gaps_sequence: %0d slots not in order 1..%0d", bad, TOTAL);
        end
    endtask

    task automatic test_abort();
        int d;
        consume(1'b0);
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.in_data = N'(50 + i);
            bus.abort   = (i == 10);
            tick();
        end
        bus.abort = 1'b0;
        checks++;
        if (bus.matrixout[1][1] !== 32'd10 || bus.matrixout[1][0] !== 32'd59) begin
            errors++; $display("[TB] FAIL abort_drop: got [1][1]=%0d [1][0]=%0d expected 10,59", bus.matrixout[1][1], bus.matrixout[1][0]);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_flags: got valid=%b ready=%b expected 0,1", bus.out_valid, bus.in_ready);
        end
        for (int k = 0; k < TOTAL; k++) begin
            bus.in_data = N'(200 + k);
            tick();
            if (k == 0) begin
                checks++;
                if (bus.vectorout[0] !== 32'd200) begin
                    errors++; $display("[TB] FAIL abort_restart: vectorout[0]=%0d expected 200", bus.vectorout[0]);
                end
            end
            checks++;
            if (bus.out_valid !== (k == TOTAL - 1)) begin
                errors++; $display("[TB] FAIL abort_reload_valid at %0d: got %b expected %b", k, bus.out_valid, (k == TOTAL - 1));
            end
        end
        d = content_diffs();
        checks++;
        if (d !== 0) begin
            errors++; $display("[TB] FAIL abort_contents: %0d slots differ from model", d);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.reuse_vec = 1'b1;
        bus.abort     = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        bus.reuse_vec = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_vs_handshake_valid: got %b expected 0", bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd77;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.vectorout[0] !== 32'd77) begin
            errors++; $display("[TB] FAIL abort_vs_handshake_slot: vectorout[0]=%0d expected 77", bus.vectorout[0]);
        end
    endtask

    task automatic test_hold();
        int d;
        bus.abort = 1'b1;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            bus.in_data = N'($urandom);
            tick();
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_start: out_valid=%b expected 1", bus.out_valid);
        end
        for (int k = 0; k < 50; k++) begin
            bus.in_data   = N'($urandom);
            bus.reuse_vec = 1'($urandom_range(0, 1));
            tick();
            d = content_diffs();
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || d !== 0) begin
                errors++; $display("[TB] FAIL hold cycle %0d: ready=%b valid=%b diffs=%0d expected 0,1,0", k, bus.in_ready, bus.out_valid, d);
            end
        end
        bus.in_valid  = 1'b0;
        bus.reuse_vec = 1'b0;
    endtask

    task automatic test_mid_reset();
        int bad;
        consume(1'b0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < LEN + 2 * LEN + 1; i++) begin
            bus.in_data = N'(300 + i);
            tick();
        end
        reset       = 1'b1;
        bus.in_data = 32'h55;
        tick();
        bad = 0;
        for (int v = 0; v < LEN; v++)
            if (bus.vectorout[v] !== '0) bad++;
        for (int r = 0; r < WIDTH; r++)
            for (int c = 0; c < LEN; c++)
                if (bus.matrixout[r][c] !== '0) bad++;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bad !== 0) begin
            errors++; $display("[TB] FAIL mid_reset: valid=%b ready=%b nonzero=%0d expected 0,0,0", bus.out_valid, bus.in_ready, bad);
        end
        reset       = 1'b0;
        bus.in_data = 32'h66;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.vectorout[0] !== 32'h66 || bus.vectorout[1] !== '0 || bus.matrixout[2][1] !== '0) begin
            errors++; $display("[TB] FAIL mid_reset_restart: got %0h,%0h,%0h expected 66,0,0", bus.vectorout[0], bus.vectorout[1], bus.matrixout[2][1]);
        end
    endtask

    initial begin
        m_pos     = 0;
        m_full    = 0;
        m_accepts = 0;
        test_reset();
        test_full_load();
        test_reuse();
        test_random_gaps();
        test_abort();
        test_hold();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
